loa_adder_pipe: RTL

Parametrised, pipelined successor to the fixed 32-bit lower-part-OR approximate adder. Width, maximum lower-part length and pipeline depth are parameters. The lower-part length is selectable per transaction at runtime, with length 0 giving exact addition. Operands and results use a valid/ready stream handshake, and a built-in error monitor compares every result against the exact sum. It sits between operand producers and the accuracy-characterisation logic in approximate datapaths.

---
 rtl/loa_pkg.sv | 12 +
 rtl/loa_stage.sv | 30 +++
 rtl/loa_adder_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/loa_pkg.sv
// Shared helpers for the lower-part-OR approximate adder pipeline.
package loa_pkg;

    function automatic int lp_width(input int lp_max);
        return $clog2(lp_max + 1);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/loa_stage.sv
// One pipeline slot: payload register plus valid bit, ready passed back combinationally.
module loa_stage #(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);
    logic          r_valid;
    logic [DW-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) r_data <= i_data;
        end
    end
endmodule

// File: rtl/loa_adder_pipe.sv
// Pipelined lower-part-OR approximate adder with per-transaction lower-part length
// and an on-line error monitor against the exact sum.
module loa_adder_pipe import loa_pkg::*; #(
    parameter int WIDTH  = 32,
    parameter int LP_MAX = 8,
    parameter int STAGES = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [WIDTH-1:0]              add1_i,
    input  logic [WIDTH-1:0]              add2_i,
    input  logic [lp_width(LP_MAX)-1:0]   lp_len_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [WIDTH:0]                result_o,
    output logic [WIDTH+1:0]              err_o,
    input  logic                          stat_clr_i,
    output logic [31:0]                   err_cnt_o,
    output logic [WIDTH:0]                err_max_o
);
    localparam int LW = lp_width(LP_MAX);
    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [LW-1:0]    l;
        logic [WIDTH:0]   psum;
        logic             carry;
    } pay_t;
    localparam int DW = $bits(pay_t);

    function automatic logic [WIDTH-1:0] lo_mask(input logic [LW-1:0] l);
        return WIDTH'((ONE << l) - ONE);
    endfunction

    // Lower OR part and the carry taken from bit L-1 (m ^ m>>1 isolates that bit).
    function automatic pay_t front(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [LW-1:0] l_in);
        pay_t             p;
        logic [WIDTH-1:0] m;
        p.a     = a;
        p.b     = b;
        p.l     = (l_in > LW'(LP_MAX)) ? LW'(LP_MAX) : l_in;
        m       = lo_mask(p.l);
        p.psum  = {1'b0, (a | b) & m};
        p.carry = |(a & b & (m ^ (m >> 1)));
        return p;
    endfunction

    function automatic pay_t finish(input pay_t p);
        pay_t             q;
        logic [WIDTH-1:0] hm;
        hm     = ~lo_mask(p.l);
        q      = p;
        q.psum = ({1'b0, p.a & hm} + {1'b0, p.b & hm} + ((WIDTH+1)'(p.carry) << p.l))
               | {1'b0, p.psum[WIDTH-1:0]};
        return q;
    endfunction

    logic [STAGES-1:0] w_vld_in, w_rdy_in, w_vld_out, w_rdy_out;
    pay_t [STAGES-1:0] w_din, w_dout;
    pay_t              w_last;
    logic [WIDTH:0]    w_exact, w_abs;
    logic [WIDTH+1:0]  w_err;
    logic              w_hs;
    logic [31:0]       r_cnt;
    logic [WIDTH:0]    r_max;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_front
            assign w_vld_in[k] = in_valid_i;
            assign w_din[k]    = front(add1_i, add2_i, lp_len_i);
        end else if (k == 1) begin : g_upper
            assign w_vld_in[k] = w_vld_out[k-1];
            assign w_din[k]    = finish(w_dout[k-1]);
        end else begin : g_pass
            assign w_vld_in[k] = w_vld_out[k-1];
            assign w_din[k]    = w_dout[k-1];
        end
        if (k == STAGES-1) begin : g_rdy_last
            assign w_rdy_out[k] = out_ready_i;
        end else begin : g_rdy_mid
            assign w_rdy_out[k] = w_rdy_in[k+1];
        end
        loa_stage #(.DW(DW)) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .i_valid (w_vld_in[k]),
            .o_ready (w_rdy_in[k]),
            .i_data  (w_din[k]),
            .o_valid (w_vld_out[k]),
            .i_ready (w_rdy_out[k]),
            .o_data  (w_dout[k])
        );
    end

    // With a single register the upper part is finished after it instead.
    if (STAGES == 1) begin : g_out1
        assign w_last = finish(w_dout[0]);
    end else begin : g_outn
        assign w_last = w_dout[STAGES-1];
    end

    assign w_exact = {1'b0, w_last.a} + {1'b0, w_last.b};
    assign w_err   = {1'b0, w_last.psum} - {1'b0, w_exact};
    assign w_abs   = w_err[WIDTH+1] ? (WIDTH+1)'(-w_err) : w_err[WIDTH:0];
    assign w_hs    = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || stat_clr_i) begin
            r_cnt <= '0;
            r_max <= '0;
        end else if (w_hs) begin
            if (w_err != '0) r_cnt <= sat_inc(r_cnt);
            if (w_abs > r_max) r_max <= w_abs;
        end
    end

    assign in_ready_o  = w_rdy_in[0];
    assign out_valid_o = w_vld_out[STAGES-1];
    assign result_o    = w_last.psum;
    assign err_o       = w_err;
    assign err_cnt_o   = r_cnt;
    assign err_max_o   = r_max;
endmodule
